// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch sequencer for a small program ROM. It owns the program
// counter, drives the ROM address, latches each fetched instruction and
// resolves control flow locally:
//   - jmp (4'b1000): unconditional redirect to inst[11:8]; never issued.
//   - br  (4'b1100): waits for execute to drain (exec_idle) and redirects to
//                    inst[11:8] when zero_flag is set; never issued.
//   - anything else: issued to execute over a valid/ready handshake.
// A jmp whose target equals its own address sets the sticky halted flag; the
// unit keeps looping on it (one redirect every two cycles).
//
// Ports
//   clk          in   clock, rising edge
//   rst          in   synchronous active-high reset
//   rom_addr     out  ROM address (equals the PC, combinational)
//   rom_data     in   ROM word for rom_addr, valid in the same cycle
//   inst         out  instruction register presented to execute
//   inst_valid   out  inst is valid for execute
//   inst_ready   in   execute accepts inst this cycle
//   exec_idle    in   execute has nothing in flight, zero_flag is settled
//   zero_flag    in   last retired result was zero
//   pc_out       out  address of the instruction held in inst
//   branch_taken out  one-cycle pulse on every PC redirect
//   halted       out  sticky self-jump indicator
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter int ADDR_W = 4,
    parameter int INST_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [INST_W-1:0] rom_data,
    output logic [INST_W-1:0] inst,
    output logic              inst_valid,
    input  logic              inst_ready,
    input  logic              exec_idle,
    input  logic              zero_flag,
    output logic [ADDR_W-1:0] pc_out,
    output logic              branch_taken,
    output logic              halted
);

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        ISSUE  = 2'd1,
        BRWAIT = 2'd2
    } state_t;

    localparam logic [3:0]        OP_JMP = 4'b1000;
    localparam logic [3:0]        OP_BR  = 4'b1100;
    localparam logic [ADDR_W-1:0] PC_ONE = ADDR_W'(1);

    // Zero-extends or truncates the 4-bit target field to the PC width.
    function automatic logic [ADDR_W-1:0] jump_target(input logic [3:0] field);
        logic [ADDR_W-1:0] t;
        t = '0;
        for (int i = 0; i < ADDR_W && i < 4; i++) begin
            t[i] = field[i];
        end
        return t;
    endfunction

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [INST_W-1:0]   inst_q, inst_d;
    logic [ADDR_W-1:0]   pc_out_q, pc_out_d;
    logic                halted_q, halted_d;
    logic                inst_valid_s;
    logic                branch_taken_s;
    logic [3:0]          opcode_s;
    logic [ADDR_W-1:0]   target_s;

    assign opcode_s = inst_q[15:12];
    assign target_s = jump_target(inst_q[11:8]);

    // Next-state, datapath updates and the combinational handshake/redirect outputs.
    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        inst_d         = inst_q;
        pc_out_d       = pc_out_q;
        halted_d       = halted_q;
        inst_valid_s   = 1'b0;
        branch_taken_s = 1'b0;

        case (state_q)
            FETCH: begin
                // PC wraps naturally at 2^ADDR_W.
                inst_d   = rom_data;
                pc_out_d = pc_q;
                pc_d     = pc_q + PC_ONE;
                state_d  = ISSUE;
            end

            ISSUE: begin
                if (opcode_s == OP_JMP) begin
                    pc_d           = target_s;
                    branch_taken_s = 1'b1;
                    if (target_s == pc_out_q) begin
                        halted_d = 1'b1;
                    end else begin
                        halted_d = halted_q;
                    end
                    state_d = FETCH;
                end else if (opcode_s == OP_BR) begin
                    // Resolve at once when execute is already drained.
                    if (exec_idle) begin
                        if (zero_flag) begin
                            pc_d           = target_s;
                            branch_taken_s = 1'b1;
                        end else begin
                            pc_d = pc_q;
                        end
                        state_d = FETCH;
                    end else begin
                        state_d = BRWAIT;
                    end
                end else begin
                    inst_valid_s = 1'b1;
                    if (inst_ready) begin
                        state_d = FETCH;
                    end else begin
                        state_d = ISSUE;
                    end
                end
            end

            BRWAIT: begin
                // zero_flag only means something once execute is idle.
                if (exec_idle) begin
                    if (zero_flag) begin
                        pc_d           = target_s;
                        branch_taken_s = 1'b1;
                    end else begin
                        pc_d = pc_q;
                    end
                    state_d = FETCH;
                end else begin
                    state_d = BRWAIT;
                end
            end

            default: begin
                state_d = FETCH;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= FETCH;
            pc_q     <= '0;
            inst_q   <= '0;
            pc_out_q <= '0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            inst_q   <= inst_d;
            pc_out_q <= pc_out_d;
            halted_q <= halted_d;
        end
    end

    assign rom_addr     = pc_q;
    assign inst         = inst_q;
    assign pc_out       = pc_out_q;
    assign halted       = halted_q;
    assign inst_valid   = inst_valid_s;
    // A redirect decided in a reset cycle never takes effect, so do not flag it.
    assign branch_taken = branch_taken_s & ~rst;

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//
// Drives fetch_unit from a bench-owned ROM with directed scenarios (issue,
// backpressure, br taken/not taken with stalls, jmp, self-jump halt, PC wrap,
// reset in BRWAIT and in a stalled ISSUE). A program-level model (next fetch
// address, held instruction, fetch/hold phase) predicts every output on every
// non-reset cycle; directed literal checks pin the model.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic [3:0]  rom_addr;
    logic [15:0] rom_data;
    logic [15:0] inst;
    logic        inst_valid;
    logic        inst_ready;
    logic        exec_idle;
    logic        zero_flag;
    logic [3:0]  pc_out;
    logic        branch_taken;
    logic        halted;

    logic [15:0] rom [16];

    int checks;
    int errors;
    int hs_cnt;

    // Program-level model
    int          m_pc;
    bit          m_fetch;
    logic [15:0] m_inst;
    int          m_pcout;
    bit          m_halt;

    fetch_unit #(.ADDR_W(4), .INST_W(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .rom_addr     (rom_addr),
        .rom_data     (rom_data),
        .inst         (inst),
        .inst_valid   (inst_valid),
        .inst_ready   (inst_ready),
        .exec_idle    (exec_idle),
        .zero_flag    (zero_flag),
        .pc_out       (pc_out),
        .branch_taken (branch_taken),
        .halted       (halted)
    );

    assign rom_data = rom[rom_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    // Advance until the instruction register holds w, bounded by budget cycles.
    task automatic wait_inst(input logic [15:0] w, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (inst == w) break;
            tick();
        end
        chk("wait_inst", 32'(inst), 32'(w));
    endtask

    task automatic load_prog_a();
        for (int i = 0; i < 16; i++) rom[i] = 16'h2000 + 16'(i);
        rom[0]  = 16'h1E03;
        rom[1]  = 16'h2001;
        rom[2]  = 16'h3002;
        rom[3]  = 16'hF000;
        rom[4]  = 16'hCA00;
        rom[5]  = 16'h8300;
        rom[10] = 16'h2222;
        rom[11] = 16'h8B00;
    endtask

    // Per-cycle model compare at the falling edge, then model advance.
    initial begin
        logic [3:0] op;
        int         tgt;
        bit         e_valid;
        bit         e_bt;
        m_pc = 0; m_fetch = 1'b1; m_inst = 16'h0000; m_pcout = 0; m_halt = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                m_pc = 0; m_fetch = 1'b1; m_inst = 16'h0000; m_pcout = 0; m_halt = 1'b0;
            end else begin
                op      = m_inst[15:12];
                tgt     = int'(m_inst[11:8]);
                e_valid = !m_fetch && op != 4'h8 && op != 4'hC;
                e_bt    = !m_fetch && (op == 4'h8 || (op == 4'hC && exec_idle && zero_flag));
                chk("m_rom_addr", 32'(rom_addr), 32'(m_pc));
                chk("m_inst", 32'(inst), 32'(m_inst));
                chk("m_pc_out", 32'(pc_out), 32'(m_pcout));
                chk("m_inst_valid", 32'(inst_valid), 32'(e_valid));
                chk("m_branch_taken", 32'(branch_taken), 32'(e_bt));
                chk("m_halted", 32'(halted), 32'(m_halt));
                if (inst_valid && inst_ready) hs_cnt++;
                if (m_fetch) begin
                    m_inst  = rom[m_pc];
                    m_pcout = m_pc;
                    m_pc    = (m_pc + 1) % 16;
                    m_fetch = 1'b0;
                end else if (op == 4'h8) begin
                    if (tgt == m_pcout) m_halt = 1'b1;
                    m_pc    = tgt;
                    m_fetch = 1'b1;
                end else if (op == 4'hC) begin
                    if (exec_idle) begin
                        if (zero_flag) m_pc = tgt;
                        m_fetch = 1'b1;
                    end
                end else if (inst_ready) begin
                    m_fetch = 1'b1;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int  hs0;
        bit  last15;
        bit  wrapped;
        checks = 0; errors = 0; hs_cnt = 0;
        load_prog_a();
        rst = 1'b1; inst_ready = 1'b1; exec_idle = 1'b1; zero_flag = 1'b0;
        repeat (3) tick();
        rst = 1'b0;

        // Reset and first issue
        mid(); chk("c0_rom_addr", 32'(rom_addr), 32'd0); chk("c0_valid", 32'(inst_valid), 32'd0);
        chk("c0_inst", 32'(inst), 32'd0);
        tick(); mid();
        chk("c1_inst", 32'(inst), 32'h1E03); chk("c1_valid", 32'(inst_valid), 32'd1);
        chk("c1_pc_out", 32'(pc_out), 32'd0);
        tick(); mid(); chk("c2_rom_addr", 32'(rom_addr), 32'd1);

        // Backpressure on word 1 for 5 cycles
        tick(); inst_ready = 1'b0; hs0 = hs_cnt;
        for (int i = 0; i < 5; i++) begin
            mid();
            chk("bp_inst", 32'(inst), 32'h2001); chk("bp_pc_out", 32'(pc_out), 32'd1);
            chk("bp_valid", 32'(inst_valid), 32'd1);
            tick();
        end
        inst_ready = 1'b1; mid(); tick();
        chk("bp_accepts", 32'(hs_cnt - hs0), 32'd1);
        mid(); chk("bp_rom_addr", 32'(rom_addr), 32'd2);

        // br at word 4, exec busy 3 cycles, then taken
        exec_idle = 1'b0;
        wait_inst(16'hCA00, 20);
        mid(); chk("br_valid", 32'(inst_valid), 32'd0); chk("br_stall_addr0", 32'(rom_addr), 32'd5);
        tick(); mid(); chk("br_stall_addr1", 32'(rom_addr), 32'd5);
        tick(); mid(); chk("br_stall_bt", 32'(branch_taken), 32'd0);
        tick(); exec_idle = 1'b1; zero_flag = 1'b1;
        mid(); chk("br_taken", 32'(branch_taken), 32'd1);
        tick(); zero_flag = 1'b0;
        mid(); chk("br_target_addr", 32'(rom_addr), 32'd10); chk("br_bt_clear", 32'(branch_taken), 32'd0);

        // Self-jump at word 11
        wait_inst(16'h8B00, 10);
        mid(); chk("halt_jmp_valid", 32'(inst_valid), 32'd0); chk("halt_jmp_bt", 32'(branch_taken), 32'd1);
        chk("halt_pre", 32'(halted), 32'd0);
        tick(); mid(); chk("halt_set", 32'(halted), 32'd1); chk("halt_addr", 32'(rom_addr), 32'd11);
        repeat (6) tick();
        mid(); chk("halt_sticky", 32'(halted), 32'd1);

        // Reset clears halted
        tick(); rst = 1'b1; tick(); rst = 1'b0;
        mid(); chk("rst1_halted", 32'(halted), 32'd0); chk("rst1_addr", 32'(rom_addr), 32'd0);
        chk("rst1_valid", 32'(inst_valid), 32'd0);

        // br not taken after 3 busy cycles
        exec_idle = 1'b0;
        wait_inst(16'hCA00, 20);
        mid(); tick(); mid(); tick(); mid();
        tick(); exec_idle = 1'b1; zero_flag = 1'b0;
        mid(); chk("brnt_bt", 32'(branch_taken), 32'd0);
        tick(); mid(); chk("brnt_addr", 32'(rom_addr), 32'd5); chk("brnt_pc_out", 32'(pc_out), 32'd4);

        // jmp at word 5 to 3
        wait_inst(16'h8300, 10);
        mid(); chk("jmp_valid", 32'(inst_valid), 32'd0); chk("jmp_bt", 32'(branch_taken), 32'd1);
        tick(); mid(); chk("jmp_addr", 32'(rom_addr), 32'd3); chk("jmp_halted", 32'(halted), 32'd0);

        // Reset during BRWAIT
        exec_idle = 1'b0;
        wait_inst(16'hCA00, 10);
        tick(); rst = 1'b1; tick(); rst = 1'b0;
        mid(); chk("rstbw_valid", 32'(inst_valid), 32'd0); chk("rstbw_addr", 32'(rom_addr), 32'd0);
        chk("rstbw_pc_out", 32'(pc_out), 32'd0); chk("rstbw_inst", 32'(inst), 32'd0);

        // Reset during stalled ISSUE; handshake in the reset cycle is void
        exec_idle = 1'b1; inst_ready = 1'b0;
        tick(); mid(); chk("stall_valid", 32'(inst_valid), 32'd1);
        tick(); hs0 = hs_cnt; rst = 1'b1; inst_ready = 1'b1;
        tick(); rst = 1'b0;
        mid(); chk("rstis_valid", 32'(inst_valid), 32'd0); chk("rstis_addr", 32'(rom_addr), 32'd0);
        chk("rstis_halted", 32'(halted), 32'd0);
        tick(); chk("rstis_void_hs", 32'(hs_cnt - hs0), 32'd0);

        // PC wrap with 16 issuable words
        rst = 1'b1;
        for (int i = 0; i < 16; i++) rom[i] = 16'h1000 + 16'(i);
        tick(); rst = 1'b0;
        last15 = 1'b0; wrapped = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (last15 && pc_out == 4'd0) wrapped = 1'b1;
            last15 = (pc_out == 4'd15);
        end
        chk("wrap_15_to_0", 32'(wrapped), 32'd1);

        tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch sequencer that reads the 16-entry program ROM. It owns the program counter, drives the ROM address, and latches each 16-bit instruction. It resolves `jmp` and `br` locally and issues every other instruction to the execute stage over a valid/ready handshake. It sits between the program ROM and the execute/register-file datapath.

## Interface
- `ADDR_W`, default 4: PC and ROM address width. The address space is 2^ADDR_W words.
- `INST_W`, default 16: instruction width.

- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `rom_addr`  out  ADDR_W: ROM address, driven combinationally as `pc`.
- `rom_data`  in  INST_W: ROM word for `rom_addr`. It is combinational and valid in the same cycle.
- `inst`  out  INST_W: instruction register presented to execute.
- `inst_valid`  out  1: `inst` is valid for execute.
- `inst_ready`  in  1: execute accepts `inst` this cycle.
- `exec_idle`  in  1: execute has no instruction in flight, and `zero_flag` reflects the last retired instruction.
- `zero_flag`  in  1: result of the last retired instruction was zero.
- `pc_out`  out  ADDR_W: address of the instruction held in `inst` (debug/out).
- `branch_taken`  out  1: one-cycle pulse when `jmp` or taken `br` redirects the PC.
- `halted`  out  1: sticky flag; a `jmp` whose target equals its own address was decoded.

## Operation
- Opcode is `inst[15:12]`. `jmp` is 4'b1000; `br` is 4'b1100. The target for both is `inst[11:8]`, zero-extended or truncated to ADDR_W.
- All other opcodes (load 0001, add 0010, sub 0011, subi 1011, mov 1110, out 1111, undefined) are issued unmodified.
- State machine has states FETCH, ISSUE, BRWAIT:
  - FETCH:
    - `inst <= rom_data`, `pc_out <= pc`, `pc <= pc+1`.
    - PC wraps modulo 2^ADDR_W, so 15 -> 0.
    - Go to ISSUE.
  - ISSUE, opcode `jmp`:
    - `pc <= target`, pulse `branch_taken`.
    - Set `halted` if target == `pc_out`.
    - Go to FETCH. `inst_valid` stays 0.
  - ISSUE, opcode `br`:
    - If `exec_idle` = 1 this cycle, behave as BRWAIT resolution immediately.
    - Otherwise go to BRWAIT.
  - ISSUE, any other opcode:
    - `inst_valid` = 1.
    - On `inst_valid & inst_ready`, go to FETCH.
    - Otherwise hold. `inst` and `pc_out` stay stable while valid and not accepted.
  - BRWAIT, resolution:
    - Wait for `exec_idle` = 1.
    - In that cycle, if `zero_flag` = 1: `pc <= target` and pulse `branch_taken`. If 0: the PC keeps its fall-through value.
    - Go to FETCH.
- `inst_valid` is asserted only in ISSUE for issued opcodes. It is combinational from state and opcode, and never depends on `inst_ready`.
- `halted` stops nothing. The unit keeps looping on the self-jump, one redirect every 2 cycles.
- Reset values: `pc`=0, state=FETCH, `inst`=0, `pc_out`=0, `inst_valid`=0, `branch_taken`=0, `halted`=0.
- Reset mid-operation: on any cycle, `rst`=1 overrides all transitions, including a pending handshake or BRWAIT. A handshake in the same cycle as `rst` is void.

## Timing
- Cycle 0 is the first cycle with `rst`=0: FETCH, with `rom_addr`=0.
- Cycle 1: ISSUE with `inst`=word 0. `inst_valid`=1 if the word is issuable.
- Throughput is 2 cycles per issued instruction with `inst_ready` held high.
- `jmp` costs 2 cycles with no issue. `branch_taken` is high in the ISSUE cycle, and the next FETCH reads the target.
- `br` costs 2 cycles minimum. Each cycle of `exec_idle`=0 adds one.
- `zero_flag` is sampled only in the cycle where `exec_idle`=1 resolves the branch.

## Test plan
- Reset and issue:
  - Stimulus: ROM word0=16'h1E03, `inst_ready`=1.
  - Required: cycle 1 shows `inst`=16'h1E03, `inst_valid`=1, `pc_out`=0; cycle 2 shows `rom_addr`=1.
- Backpressure:
  - Stimulus: `inst_ready`=0 for 5 cycles in ISSUE, then 1.
  - Required: `inst` and `pc_out` hold for all 5 cycles, exactly one acceptance occurs, then the PC advances by 1.
- jmp:
  - Stimulus: word5=16'h8300.
  - Required: no `inst_valid` for it; `branch_taken` pulses; next `rom_addr`=3; `halted` stays 0.
  - Stimulus: word11=16'h8B00.
  - Required: `halted` rises and stays 1.
- br:
  - Stimulus: word4=16'hCA00 with `exec_idle` low for 3 cycles, then high with `zero_flag`=1.
  - Required: the unit stalls 3 cycles, then `rom_addr`=10.
  - Stimulus: repeat with `zero_flag`=0.
  - Required: `rom_addr`=5 and no `branch_taken`.
- Wrap:
  - Stimulus: 16 issuable words, `inst_ready`=1.
  - Required: `pc_out` goes 15 then 0.
- Mid-op reset:
  - Stimulus: assert `rst` during BRWAIT and again during a stalled ISSUE.
  - Required: next cycle has `inst_valid`=0, `pc`=0, `halted`=0, state FETCH.
